// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns each load/store into one req/ack bus
// transaction with byte/half lane steering, load extension, alignment checks
// and a bus timeout. Stalls upstream stages while a transaction is in flight.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  MemOp,
  input  logic [31:0] ALU_result,
  input  logic [31:0] WriteData,
  output logic [31:0] MemData,
  output logic        MEM_Stall,
  output logic        MEM_WB_Bubble,
  output logic        AddrError,
  output logic        BusError,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t      r_state;
  state_t      w_next;

  logic        w_access;
  logic        w_misaligned;
  logic        w_start;
  logic        w_timeout;
  size_t       w_size;
  size_t       w_rsize;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_lane8;
  logic [15:0] w_lane16;
  logic [31:0] w_ext;

  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_op;
  logic [1:0]  r_off;
  logic [15:0] r_cnt;
  logic [31:0] r_rdata;
  logic        r_berr;

  function automatic size_t size_of(input logic [2:0] op);
    case (op)
      3'b000, 3'b100: size_of = SZ_BYTE;
      3'b001, 3'b101: size_of = SZ_HALF;
      default:        size_of = SZ_WORD;
    endcase
  endfunction

  // Request decode, alignment check and store lane steering from EX/MEM inputs
  always_comb begin
    w_access     = MemRead | MemWrite;
    w_size       = size_of(MemOp);
    w_misaligned = ((w_size == SZ_HALF) && ALU_result[0]) ||
                   ((w_size == SZ_WORD) && (ALU_result[1:0] != 2'b00));
    w_start      = w_access & ~w_misaligned;
    w_timeout    = (r_cnt == 16'(TIMEOUT - 1));
    w_be         = 4'b1111;
    w_wdata      = WriteData;
    case (w_size)
      SZ_BYTE: begin
        w_be    = 4'b0001 << ALU_result[1:0];
        w_wdata = {4{WriteData[7:0]}};
      end
      SZ_HALF: begin
        w_be    = ALU_result[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WriteData[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = WriteData;
      end
    endcase
  end

  // Load lane selection and sign/zero extension using the captured op/offset
  always_comb begin
    w_rsize = size_of(r_op);
    case (r_off)
      2'd0:    w_lane8 = mem_rdata[7:0];
      2'd1:    w_lane8 = mem_rdata[15:8];
      2'd2:    w_lane8 = mem_rdata[23:16];
      default: w_lane8 = mem_rdata[31:24];
    endcase
    w_lane16 = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (w_rsize)
      SZ_BYTE: w_ext = {{24{~r_op[2] & w_lane8[7]}}, w_lane8};
      SZ_HALF: w_ext = {{16{~r_op[2] & w_lane16[15]}}, w_lane16};
      default: w_ext = mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; an ack in the timeout cycle takes priority
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_BUSY;
      S_BUSY:  if (mem_ack || w_timeout) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs to the pipeline
  always_comb begin
    MEM_Stall     = 1'b0;
    AddrError     = 1'b0;
    MemData       = '0;
    case (r_state)
      S_IDLE: begin
        MEM_Stall = w_start;
        AddrError = w_access & w_misaligned;
      end
      S_BUSY:  MEM_Stall = 1'b1;
      S_DONE:  MemData   = r_rdata;
      default: MEM_Stall = 1'b0;
    endcase
    MEM_WB_Bubble = MEM_Stall;
    BusError      = r_berr;
  end

  // Bus registers, timeout counter and captured load data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_op    <= '0;
      r_off   <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_berr  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_berr <= 1'b0;
          if (w_start) begin
            r_req   <= 1'b1;
            r_we    <= MemWrite;
            r_addr  <= {ALU_result[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_op    <= MemOp;
            r_off   <= ALU_result[1:0];
            r_cnt   <= '0;
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            r_req   <= 1'b0;
            r_rdata <= r_we ? '0 : w_ext;
          end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_rdata <= '0;
            r_berr  <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + 16'd1;
          end
        end
        default: r_berr <= 1'b0;
      endcase
    end
  end

  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_be    = r_be;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (TIMEOUT overridden to 4).
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  MemOp;
  logic [31:0] ALU_result, WriteData;
  logic [31:0] MemData;
  logic        MEM_Stall, MEM_WB_Bubble, AddrError, BusError;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemOp(MemOp), .ALU_result(ALU_result), .WriteData(WriteData),
    .MemData(MemData), .MEM_Stall(MEM_Stall), .MEM_WB_Bubble(MEM_WB_Bubble),
    .AddrError(AddrError), .BusError(BusError), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemOp      = 3'b000;
    ALU_result = '0;
    WriteData  = '0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h5A5A_5A5A;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req"},    32'(mem_req),       32'd0);
    chk({tag, ".we"},     32'(mem_we),        32'd0);
    chk({tag, ".addr"},   mem_addr,           32'd0);
    chk({tag, ".be"},     32'(mem_be),        32'd0);
    chk({tag, ".wdata"},  mem_wdata,          32'd0);
    chk({tag, ".mdata"},  MemData,            32'd0);
    chk({tag, ".stall"},  32'(MEM_Stall),     32'd0);
    chk({tag, ".bubble"}, 32'(MEM_WB_Bubble), 32'd0);
    chk({tag, ".aerr"},   32'(AddrError),     32'd0);
    chk({tag, ".berr"},   32'(BusError),      32'd0);
  endtask

  // One access: cycle 0 in IDLE, nbusy BUSY cycles (ack in the last if ack_last), DONE, IDLE
  task automatic run_txn(input string tag, input logic rd, input logic wr,
                         input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input int unsigned nbusy,
                         input logic ack_last, input logic [31:0] rdata,
                         input logic [31:0] e_addr, input logic [3:0] e_be,
                         input logic [31:0] e_wd, input logic [31:0] e_md,
                         input logic e_berr);
    cyc();
    MemRead = rd; MemWrite = wr; MemOp = op; ALU_result = addr; WriteData = wd;
    mem_ack = 1'b0;
    smp();
    chk({tag, ".c0_stall"}, 32'(MEM_Stall), 32'd1);
    chk({tag, ".c0_req"},   32'(mem_req),   32'd0);
    chk({tag, ".c0_aerr"},  32'(AddrError), 32'd0);
    for (int i = 1; i <= int'(nbusy); i++) begin
      cyc();
      if (i == int'(nbusy) && ack_last) begin
        mem_ack = 1'b1; mem_rdata = rdata;
      end else begin
        mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A;
      end
      smp();
      chk($sformatf("%s.b%0d_req", tag, i),    32'(mem_req),       32'd1);
      chk($sformatf("%s.b%0d_stall", tag, i),  32'(MEM_Stall),     32'd1);
      chk($sformatf("%s.b%0d_bubble", tag, i), 32'(MEM_WB_Bubble), 32'd1);
      chk($sformatf("%s.b%0d_mdata", tag, i),  MemData,            32'd0);
      chk($sformatf("%s.b%0d_addr", tag, i),   mem_addr,           e_addr);
      chk($sformatf("%s.b%0d_be", tag, i),     32'(mem_be),        32'(e_be));
      chk($sformatf("%s.b%0d_wdata", tag, i),  mem_wdata,          e_wd);
      chk($sformatf("%s.b%0d_we", tag, i),     32'(mem_we),        32'(wr));
    end
    cyc();
    mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A;
    smp();
    chk({tag, ".done_stall"},  32'(MEM_Stall),     32'd0);
    chk({tag, ".done_bubble"}, 32'(MEM_WB_Bubble), 32'd0);
    chk({tag, ".done_req"},    32'(mem_req),       32'd0);
    chk({tag, ".done_mdata"},  MemData,            e_md);
    chk({tag, ".done_berr"},   32'(BusError),      32'(e_berr));
    cyc();
    idle_inputs();
    smp();
    chk({tag, ".idle_mdata"}, MemData,        32'd0);
    chk({tag, ".idle_berr"},  32'(BusError),  32'd0);
    chk({tag, ".idle_stall"}, 32'(MEM_Stall), 32'd0);
    chk({tag, ".idle_req"},   32'(mem_req),   32'd0);
  endtask

  task automatic run_mis(input string tag, input logic rd, input logic wr,
                         input logic [2:0] op, input logic [31:0] addr);
    cyc();
    MemRead = rd; MemWrite = wr; MemOp = op; ALU_result = addr;
    WriteData = 32'hFFFF_FFFF;
    smp();
    chk({tag, ".aerr"},   32'(AddrError),     32'd1);
    chk({tag, ".stall"},  32'(MEM_Stall),     32'd0);
    chk({tag, ".bubble"}, 32'(MEM_WB_Bubble), 32'd0);
    chk({tag, ".req"},    32'(mem_req),       32'd0);
    chk({tag, ".mdata"},  MemData,            32'd0);
    cyc();
    idle_inputs();
    smp();
    chk({tag, ".n_aerr"}, 32'(AddrError), 32'd0);
    chk({tag, ".n_req"},  32'(mem_req),   32'd0);
    chk({tag, ".n_stall"}, 32'(MEM_Stall), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    mem_ack = 1'b1;
    repeat (3) cyc();
    smp();
    chk_all_zero("reset");
    cyc();
    reset = 1'b0;
    idle_inputs();

    // Aligned lw and load extension cases
    run_txn("lw",  1, 0, 3'b010, 32'h100, 32'h0, 2, 1, 32'hDEAD_BEEF, 32'h100, 4'b1111, 32'h0, 32'hDEAD_BEEF, 0);
    run_txn("lb",  1, 0, 3'b000, 32'h103, 32'h0, 1, 1, 32'h80FF_7F01, 32'h100, 4'b1000, 32'h0, 32'hFFFF_FF80, 0);
    run_txn("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 3, 1, 32'h80FF_7F01, 32'h100, 4'b1000, 32'h0, 32'h0000_0080, 0);
    run_txn("lh",  1, 0, 3'b001, 32'h102, 32'h0, 1, 1, 32'h80FF_7F01, 32'h100, 4'b1100, 32'h0, 32'hFFFF_80FF, 0);
    run_txn("lhu", 1, 0, 3'b101, 32'h100, 32'h0, 2, 1, 32'h80FF_7F01, 32'h100, 4'b0011, 32'h0, 32'h0000_7F01, 0);
    run_txn("lw011", 1, 0, 3'b011, 32'h104, 32'h0, 1, 1, 32'h89AB_CDEF, 32'h104, 4'b1111, 32'h0, 32'h89AB_CDEF, 0);

    // Stores: MemData stays 0 even with nonzero read data on the ack
    run_txn("sh", 0, 1, 3'b001, 32'h206, 32'h1234_ABCD, 1, 1, 32'hFFFF_FFFF, 32'h204, 4'b1100, 32'hABCD_ABCD, 32'h0, 0);
    run_txn("sb", 0, 1, 3'b000, 32'h201, 32'h1234_56A5, 2, 1, 32'hFFFF_FFFF, 32'h200, 4'b0010, 32'hA5A5_A5A5, 32'h0, 0);
    run_txn("sw", 0, 1, 3'b010, 32'h30C, 32'hCAFE_F00D, 1, 1, 32'hFFFF_FFFF, 32'h30C, 4'b1111, 32'hCAFE_F00D, 32'h0, 0);

    // Misaligned accesses
    run_mis("mis_lw", 1, 0, 3'b010, 32'h102);
    run_mis("mis_sh", 0, 1, 3'b001, 32'h301);
    run_mis("mis_011", 1, 0, 3'b011, 32'h105);

    // Timeout with no ack, then ack in the timeout cycle
    run_txn("tmo",     1, 0, 3'b010, 32'h500, 32'h0, 4, 0, 32'h0,         32'h500, 4'b1111, 32'h0, 32'h0,         1);
    run_txn("tmo_ack", 1, 0, 3'b010, 32'h500, 32'h0, 4, 1, 32'h1122_3344, 32'h500, 4'b1111, 32'h0, 32'h1122_3344, 0);

    // Reset in the second BUSY cycle of a store
    cyc();
    MemWrite = 1'b1; MemOp = 3'b010; ALU_result = 32'h400; WriteData = 32'h1357_2468;
    smp();
    chk("rst.c0_stall", 32'(MEM_Stall), 32'd1);
    cyc();
    smp();
    chk("rst.b1_req", 32'(mem_req), 32'd1);
    chk("rst.b1_we",  32'(mem_we),  32'd1);
    cyc();
    reset = 1'b1;
    smp();
    chk("rst.b2_req", 32'(mem_req), 32'd1);
    cyc();
    reset = 1'b0;
    idle_inputs();
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_0000;
    smp();
    chk_all_zero("rst.after");
    cyc();
    mem_ack = 1'b0;
    smp();
    chk("rst.stray_req",   32'(mem_req), 32'd0);
    chk("rst.stray_mdata", MemData,      32'd0);
    chk("rst.stray_stall", 32'(MEM_Stall), 32'd0);
    run_txn("lw_after_rst", 1, 0, 3'b010, 32'h600, 32'h0, 1, 1, 32'h0BAD_F00D, 32'h600, 4'b1111, 32'h0, 32'h0BAD_F00D, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

MEM-stage load/store unit sitting between the EX/MEM pipeline register and the MEM/WB pipeline register of the MIPS pipeline CPU. It turns each load or store into a single request/acknowledge transaction on the data-memory bus, handling byte and halfword lane steering, sign/zero extension and alignment checks. It produces `MemData` for the MEM/WB register. While a transaction is outstanding it stalls all upstream stages and feeds a bubble into MEM/WB.

## Interface
- `TIMEOUT`, 255: cycles in BUSY without `mem_ack` before a bus error is declared; allowed range 1..65535.

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `MemRead`  in  1  EX/MEM load flag.
- `MemWrite`  in  1  EX/MEM store flag. `MemRead` and `MemWrite` are never both 1.
- `MemOp`  in  3  access size:
  - 000 = byte (lb/sb), 001 = half (lh/sh), 010 = word (lw/sw), 100 = lbu, 101 = lhu.
  - Other codes are treated as word.
- `ALU_result`  in  32  byte address.
- `WriteData`  in  32  store data; the low byte or half is used for sb/sh.
- `MemData`  out  32  extended load data to MEM/WB; 0 for stores, non-accesses and errors.
- `MEM_Stall`  out  1  stall for PC, IF/ID, ID/EX and EX/MEM.
- `MEM_WB_Bubble`  out  1  drives the MEM/WB flush input.
- `AddrError`  out  1  misaligned-access pulse.
- `BusError`  out  1  timeout pulse.
- `mem_req`  out  1  bus request (registered).
- `mem_we`  out  1  bus write enable (registered).
- `mem_addr`  out  32  word-aligned bus address, `{ALU_result[31:2],2'b00}` (registered).
- `mem_be`  out  4  byte enables; bit i = byte lane i, little-endian (registered).
- `mem_wdata`  out  32  lane-replicated write data (registered).
- `mem_rdata`  in  32  bus read data; valid only in the cycle `mem_ack`=1.
- `mem_ack`  in  1  one-cycle acknowledge.

## Operation
- `access` = `MemRead` | `MemWrite`.
- `misaligned` = (half and `ALU_result[0]`) or (word and `ALU_result[1:0]`≠0).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - `access` and not misaligned: load the bus registers, move to BUSY, clear the timeout counter. `MEM_Stall`=1.
  - `access` and misaligned: `AddrError`=1 (combinational), no request, no stall, stay in IDLE. The store is suppressed and `MemData`=0.
  - otherwise: idle, no outputs asserted.
- BUSY:
  - `mem_req`=1 and `MEM_Stall`=1.
  - `mem_ack`=1: capture the extended `mem_rdata` into `rdata_q` (0 if `mem_we`), drop `mem_req` at the same edge, go to DONE.
  - counter reaches `TIMEOUT`-1 without ack: drop `mem_req`, set `rdata_q`=0, register `BusError`=1 for the DONE cycle, go to DONE.
  - otherwise: counter increments.
- DONE:
  - `MEM_Stall`=0 and `MemData`=`rdata_q`.
  - Unconditionally return to IDLE; the pipeline advances at this edge.
- `MEM_WB_Bubble` = `MEM_Stall`.
- Store lane rules:
  - sb: `mem_be` = 1<<`ALU_result[1:0]`, `mem_wdata` = {4{WriteData[7:0]}}.
  - sh: `mem_be` = `ALU_result[1]` ? 1100 : 0011, `mem_wdata` = {2{WriteData[15:0]}}.
  - sw: `mem_be` = 1111, `mem_wdata` = `WriteData`.
- Load rules:
  - `mem_be` uses the same size-based pattern as stores.
  - The selected lane is shifted to bits [7:0] or [15:0].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- An ack in IDLE or DONE is ignored.
- `MemData` is 0 whenever the FSM is not in DONE.

## Timing
- Reset: state=IDLE, counter=0, and every output is 0 (`mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`, `MemData`, `MEM_Stall`, `MEM_WB_Bubble`, `AddrError`, `BusError`).
- Reset in BUSY aborts the transaction; `mem_req` is 0 from the reset edge onward.
- Reset has priority over every other event.
- Latency: an access presented in cycle 0 with ack in cycle k (k≥1) gives:
  - `MEM_Stall` high for cycles 0..k;
  - DONE (valid `MemData`) in cycle k+1;
  - total k+2 cycles in MEM.
- Bus signals `mem_addr`, `mem_be`, `mem_wdata` and `mem_we` are stable throughout BUSY.
- `mem_req` rises at the edge ending cycle 0.
- `mem_ack` in the first BUSY cycle (k=1) is legal.
- Ack in the same cycle as the timeout: the ack wins and `BusError` stays 0.
- Because `EX/MEM` is stalled, inputs hold steady during BUSY. The block samples them only in IDLE.
- Back-to-back accesses: the next instruction's access is seen in the IDLE cycle following DONE, giving one non-stalled gap cycle.

## Test plan
- **Aligned lw:** lw at 0x100, ack at k=2 with rdata 0xDEADBEEF.
  - `mem_addr`=0x100, `mem_be`=1111.
  - Stall for 3 cycles, then `MemData`=0xDEADBEEF for 1 cycle.
- **Load extension:** rdata 0x80FF7F01.
  - lb at 0x103 → `MemData`=0xFFFFFF80.
  - lbu at 0x103 → 0x00000080.
  - lh at 0x102 → 0xFFFF80FF.
  - lhu at 0x100 → 0x00007F01.
- **Store lanes:**
  - sh of `WriteData`=0x1234ABCD at 0x206 → `mem_addr`=0x204, `mem_be`=1100, `mem_wdata`=0xABCDABCD, `mem_we`=1.
  - sb at 0x201 → `mem_be`=0010.
- **Misaligned:** lw at 0x102 and sh at 0x301 → `AddrError`=1 for one cycle; `mem_req` never rises; `MEM_Stall`=0.
- **Timeout:** `TIMEOUT`=4, no ack → `mem_req` high for 4 cycles, then DONE with `BusError`=1 and `MemData`=0, then IDLE.
  - Repeat with ack on the 4th BUSY cycle → `BusError`=0 and data is captured.
- **Reset mid-BUSY:** assert `reset` in the 2nd BUSY cycle → all outputs 0 at the next edge.
  - A subsequent stray `mem_ack` is ignored.
  - A fresh lw completes normally.
